// File: rtl/riscv_pkg.sv
// Shared constants for the execute-stage multiply/divide unit: op codes,
// FSM state encodings, iteration count and a conditional-negate helper.
package riscv_pkg;

    localparam int ITER = 32;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULHU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_REM   = 3'b110;
    localparam logic [2:0] OP_REMU  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring
// shift-subtract divide step on the 33-bit partial remainder.
module muldiv_step
    import riscv_pkg::*;
(
    input  logic        i_is_div,
    input  logic [32:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic [31:0] i_opnd,
    output logic [32:0] o_hi,
    output logic [31:0] o_lo
);

    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic [32:0] w_sum;

    // Both candidate steps are formed; the op class picks one.
    always_comb begin
        w_shift = {i_hi[31:0], i_lo[31]};
        w_diff  = w_shift - {1'b0, i_opnd};
        w_sum   = i_hi + (i_lo[0] ? {1'b0, i_opnd} : 33'd0);
        if (i_is_div) begin
            if (!w_diff[32]) begin
                o_hi = w_diff;
                o_lo = {i_lo[30:0], 1'b1};
            end else begin
                o_hi = w_shift;
                o_lo = {i_lo[30:0], 1'b0};
            end
        end else begin
            o_hi = {1'b0, w_sum[32:1]};
            o_lo = {w_sum[0], i_lo[31:1]};
        end
    end

endmodule

// File: rtl/e_muldiv_unit.sv
// Iterative 32-bit multiply/divide unit for the execute stage.
// Optional MULDIV_FAST_MUL_EN: single-cycle MUL/MULHU (IDLE -> DONE).
module e_muldiv_unit
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    md_state_e   r_state;
    md_state_e   w_state_nxt;
    logic [4:0]  r_cnt;
    logic [2:0]  r_op;
    logic [32:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_opnd;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_done;
    logic [31:0] r_result;
    logic [32:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic [31:0] w_fix_result;
    logic        w_is_div;
    logic        w_signed;
    logic        w_fast;

    assign w_is_div = op[2];
    assign w_signed = op[2] & ~op[0];

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] w_prod;
    assign w_prod = {32'd0, a} * {32'd0, b};
    assign w_fast = ~op[2];
`else
    assign w_fast = 1'b0;
`endif

    muldiv_step u_step (
        .i_is_div (r_op[2]),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_opnd   (r_opnd),
        .o_hi     (w_hi_nxt),
        .o_lo     (w_lo_nxt)
    );

    // Final result: quotient lives in r_lo, remainder / product-high in r_hi.
    always_comb begin
        if (r_op[2]) begin
            if (r_op[1]) begin
                w_fix_result = neg_if(r_hi[31:0], r_neg_r);
            end else begin
                w_fix_result = neg_if(r_lo, r_neg_q);
            end
        end else if (r_op == OP_MULHU) begin
            w_fix_result = r_hi[31:0];
        end else begin
            w_fix_result = r_lo;
        end
    end

    // Next-state logic; clear always returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (clear) begin
                    w_state_nxt = IDLE;
                end else if (start) begin
                    w_state_nxt = w_fast ? DONE : CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                if (clear) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == 5'd0) begin
                    w_state_nxt = FIX;
                end else begin
                    w_state_nxt = CALC;
                end
            end
            FIX:     w_state_nxt = clear ? IDLE : DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand latch, iteration datapath, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= 5'd0;
            r_op     <= 3'd0;
            r_hi     <= 33'd0;
            r_lo     <= 32'd0;
            r_opnd   <= 32'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 32'd0;
        end else begin
            r_done <= (r_state == DONE) && !clear;
            case (r_state)
                IDLE: begin
                    if (start && !clear) begin
                        r_op    <= op;
                        r_cnt   <= 5'(ITER - 1);
                        r_hi    <= 33'd0;
                        r_lo    <= w_is_div ? neg_if(a, w_signed & a[31]) : b;
                        r_opnd  <= w_is_div ? neg_if(b, w_signed & b[31]) : a;
                        // A zero divisor keeps the all-ones quotient unsigned-looking.
                        r_neg_q <= w_signed & (a[31] ^ b[31]) & (b != 32'd0);
                        r_neg_r <= w_signed & a[31];
`ifdef MULDIV_FAST_MUL_EN
                        if (w_fast) begin
                            r_result <= (op == OP_MULHU) ? w_prod[63:32] : w_prod[31:0];
                        end
`endif
                    end
                end
                CALC: begin
                    if (!clear) begin
                        r_hi <= w_hi_nxt;
                        r_lo <= w_lo_nxt;
                        if (r_cnt != 5'd0) begin
                            r_cnt <= r_cnt - 5'd1;
                        end
                    end
                end
                FIX: begin
                    if (!clear) begin
                        r_result <= w_fix_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state == CALC) || (r_state == FIX);
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Scoreboard bench for e_muldiv_unit: directed corner vectors, random ops,
// clear/reset aborts and start-while-busy, checked against an arithmetic model.
module tb_e_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    e_muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int busy_total = 0;
    always @(negedge clk) if (busy) busy_total <= busy_total + 1;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_total = 0;
    logic [31:0] last_res = 32'd0;

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        logic        ovf;
        p   = {32'd0, x} * {32'd0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            3'b001: return p[63:32];
            3'b100: return (y == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'($signed(x) / $signed(y)));
            3'b101: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            3'b110: return (y == 32'd0) ? x : (ovf ? 32'd0 : 32'($signed(x) % $signed(y)));
            3'b111: return (y == 32'd0) ? x : x % y;
            default: return p[31:0];
        endcase
    endfunction

    function automatic int latency(input logic [2:0] o);
        return (FAST && !o[2]) ? 1 : 34;
    endfunction

    function automatic int busy_len(input logic [2:0] o);
        return (FAST && !o[2]) ? 0 : 33;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                done_total++;
                if (sb.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("done_cycle", 32'(cyc), 32'(e.due));
                    last_res = e.res;
                end
            end
        end
    endtask

    int bt0;

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit track);
        exp_t e;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        bt0 = busy_total;
        if (track) begin
            e.res = model(o, x, y);
            e.due = cyc + latency(o);
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 120; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        issue(o, x, y, 1'b1);
        drain();
        @(negedge clk);
        #1;
        check("busy_cycles", 32'(busy_total - bt0), 32'(busy_len(o)));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    int d0;

    initial begin
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_result", result, 32'd0);

        run_op(3'b101, 32'd100, 32'd7);
        run_op(3'b111, 32'd100, 32'd7);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'b101, 32'd5, 32'd0);
        run_op(3'b111, 32'd5, 32'd0);
        run_op(3'b100, 32'hFFFF_FFFB, 32'd0);
        run_op(3'b110, 32'hFFFF_FFFB, 32'd0);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'b011, 32'd12345, 32'd678);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick());
        end

        // clear sampled on the 10th edge of a DIVU, then an immediate new start
        run_op(3'b101, 32'd1000, 32'd3);
        issue(3'b101, 32'd77, 32'd5, 1'b0);
        repeat (9) @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("clear_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        clear = 1'b0;
        check("clear_done", {31'd0, done}, 32'd0);
        check("clear_result", result, last_res);
        run_op(3'b110, 32'hFFFF_FF00, 32'd7);

        // reset mid-CALC
        issue(3'b100, 32'd99999, 32'd13, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_result", result, 32'd0);
        sb.delete();
        last_res = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst_result", result, 32'd0);

        // start re-pulsed while busy must be ignored
        d0 = done_total;
        issue(3'b101, 32'd4242, 32'd17, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            op    = 3'($urandom_range(0, 7));
            a     = $urandom;
            b     = $urandom;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        drain();
        @(negedge clk);
        #1;
        check("busy_cycles_restart", 32'(busy_total - bt0), 32'd33);
        repeat (40) @(negedge clk);
        check("done_count", 32'(done_total - d0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
